// File: rtl/axi_to_arb_bridge.sv
// axi_to_arb_bridge
//
// Purpose:
//   Converts one arbitrated L2 memory request into AXI4 transactions on a
//   32-bit master port. A read request becomes AR/R. A write request becomes
//   AW/W/B. Single-word and INCR burst requests are both supported. Read data
//   is returned with the id of the original request. Only one transaction is
//   in flight at a time.
//
// Optional feature (compile-time macro AXI_BRIDGE_ERR_STATUS_EN):
//   When the macro is defined, the module gains the output err_sticky. It is
//   set by any non-OKAY read beat or write response and is cleared only by rst.
//   When the macro is undefined, error responses are ignored.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_*                    arbitrated request (valid/pop handshake)
//   wr_valid/wr_data/wr_pop  write-data word source
//   rd_data/rd_id/rd_valid   returned read words
//   axi_ar*, axi_r*          AXI read address and read data channels
//   axi_aw*, axi_w*, axi_b*  AXI write address, write data and response channels
//   err_sticky               sticky error flag (optional feature only)

module axi_to_arb_bridge #(
  parameter int ID_W     = 2,
  parameter int AXI_ID_W = 6,
  parameter int BURST_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AXI_BRIDGE_ERR_STATUS_EN
  output logic                err_sticky,
`endif
  input  logic                req_valid,
  output logic                req_pop,
  input  logic [29:0]         req_addr,
  input  logic                req_rnw,
  input  logic [3:0]          req_be,
  input  logic [BURST_W-1:0]  req_len,
  input  logic [ID_W-1:0]     req_id,
  input  logic                wr_valid,
  input  logic [31:0]         wr_data,
  output logic                wr_pop,
  output logic [31:0]         rd_data,
  output logic [ID_W-1:0]     rd_id,
  output logic                rd_valid,
  output logic [31:0]         axi_araddr,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  output logic [3:0]          axi_arcache,
  output logic [AXI_ID_W-1:0] axi_arid,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [31:0]         axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  input  logic                axi_rvalid,
  input  logic [AXI_ID_W-1:0] axi_rid,
  output logic                axi_rready,
  output logic [31:0]         axi_awaddr,
  output logic [7:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic [3:0]          axi_awcache,
  output logic [AXI_ID_W-1:0] axi_awid,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [31:0]         axi_wdata,
  output logic [3:0]          axi_wstrb,
  output logic                axi_wlast,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t             state, state_next;
  logic [29:0]        addr_q;
  logic [3:0]         be_q;
  logic [BURST_W-1:0] len_q;
  logic [ID_W-1:0]    id_q;
  logic [BURST_W-1:0] beat_cnt;

  // The read id is not checked, because only one transaction is outstanding.
  // The response codes only feed the optional error flag.
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid, axi_rresp, axi_bresp};

  // State register, request latch and write beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      len_q    <= '0;
      id_q     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (req_pop) begin
        addr_q <= req_addr;
        be_q   <= req_be;
        len_q  <= req_len;
        id_q   <= req_id;
      end
      if (state == B && axi_bvalid)
        beat_cnt <= '0;
      else if (wr_pop)
        beat_cnt <= beat_cnt + BURST_W'(1);
    end
  end

  // Next state and handshake outputs.
  // The request is accepted combinationally in IDLE. It is never accepted
  // while reset is asserted, so a popped request cannot be lost to reset.
  always_comb begin
    state_next  = state;
    req_pop     = 1'b0;
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    wr_pop      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !rst) begin
          req_pop    = 1'b1;
          state_next = req_rnw ? AR : AW;
        end
      end
      AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_next = R;
      end
      R: begin
        axi_rready = 1'b1;
        if (axi_rvalid && axi_rlast) state_next = IDLE;
      end
      AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_next = W;
      end
      W: begin
        axi_wvalid = wr_valid;
        wr_pop     = wr_valid & axi_wready;
        if (wr_pop && axi_wlast) state_next = B;
      end
      B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both address channels carry the same latched request fields.
  // Only the valid signal of the selected channel is asserted.
  assign axi_araddr  = {addr_q, 2'b00};
  assign axi_arlen   = 8'(len_q);
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arcache = 4'b0011;
  assign axi_arid    = AXI_ID_W'(id_q);

  assign axi_awaddr  = {addr_q, 2'b00};
  assign axi_awlen   = 8'(len_q);
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awcache = 4'b0011;
  assign axi_awid    = AXI_ID_W'(id_q);

  // Read data passes straight through with zero added latency.
  assign rd_valid = axi_rvalid & axi_rready;
  assign rd_data  = axi_rdata;
  assign rd_id    = id_q;

  // The byte enables only apply to single-word writes.
  // Every beat of a burst writes the full word.
  assign axi_wdata = wr_data;
  assign axi_wstrb = (len_q == '0) ? be_q : 4'hF;
  assign axi_wlast = (state == W) && (beat_cnt == len_q);

`ifdef AXI_BRIDGE_ERR_STATUS_EN
  // Sticky error flag. It is set by any non-OKAY read beat or write response
  // and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      err_sticky <= 1'b0;
    else if ((state == R && axi_rvalid && axi_rresp != 2'b00) ||
             (state == B && axi_bvalid && axi_bresp != 2'b00))
      err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_to_arb_bridge.sv
// tb_axi_to_arb_bridge
//
// Purpose:
//   Self-checking bench for axi_to_arb_bridge. The bench acts as the request
//   source, the write-data source and a randomized AXI slave. Each request is
//   tracked by a transaction-level model with the phases request, address,
//   data and response. The model derives every expected value from the
//   request fields and from the slave data the bench drives. Build with
//   AXI_BRIDGE_ERR_STATUS_EN defined to also check err_sticky.
//
// Ports: none (top-level bench).

module tb_axi_to_arb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_pop, req_rnw;
  logic [29:0] req_addr;
  logic [3:0]  req_be;
  logic [4:0]  req_len;
  logic [1:0]  req_id;
  logic        wr_valid, wr_pop;
  logic [31:0] wr_data, rd_data;
  logic [1:0]  rd_id;
  logic        rd_valid;
  logic [31:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic [5:0]  axi_arid, axi_awid, axi_rid;
  logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready;
`ifdef AXI_BRIDGE_ERR_STATUS_EN
  logic        err_sticky;
  bit          exp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axi_to_arb_bridge #(.ID_W(2), .AXI_ID_W(6), .BURST_W(5)) dut (
    .clk(clk), .rst(rst),
`ifdef AXI_BRIDGE_ERR_STATUS_EN
    .err_sticky(err_sticky),
`endif
    .req_valid(req_valid), .req_pop(req_pop), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_be(req_be), .req_len(req_len), .req_id(req_id),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_id(rd_id), .rd_valid(rd_valid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arid(axi_arid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rid(axi_rid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awid(axi_awid),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

  // Single comparison point. It counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compares the sticky flag with the model, then folds in this cycle's event.
  task automatic trackErr(input bit ev);
`ifdef AXI_BRIDGE_ERR_STATUS_EN
    checkOutput("err_sticky", err_sticky, exp_err);
    if (ev) exp_err = 1'b1;
`else
    if (ev) n_checks = n_checks + 0;
`endif
  endtask

  // Slave idle values with fresh random payloads.
  // Error responses are rare so that the sticky flag stays clear for a while.
  task automatic quietSlave();
    axi_arready = 1'b0; axi_awready = 1'b0;
    axi_rvalid  = 1'b0; axi_rlast   = 1'b0;
    axi_rdata   = $urandom;
    axi_rresp   = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
    axi_rid     = 6'($urandom);
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = ($urandom % 6 == 0) ? 2'b10 : 2'b00;
    wr_valid    = 1'b0;
    wr_data     = $urandom;
  endtask

  // Runs one request through its phases.
  // Phases: 1 address, 2 data, 3 response, 4 done, 5 aborted by reset.
  // abort_beat >= 0 pulses reset in the read data phase after that many beats.
  task automatic applyStimulus(input logic rnw, input logic [29:0] addr, input logic [4:0] len,
                               input logic [3:0] be, input logic [1:0] id, input int gap,
                               input int abort_beat);
    logic [31:0] wd [32];
    int   phase = 1;
    int   beat  = 0;
    bit   err_ev;
    for (int i = 0; i < 32; i++) wd[i] = $urandom;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; quietSlave(); #1;
      checkOutput("idle_pop", req_pop, 0);
      trackErr(0);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_rnw = rnw; req_addr = addr;
    req_len = len; req_be = be; req_id = id;
    quietSlave(); #1;
    checkOutput("req_pop", req_pop, 1);
    trackErr(0);
    for (int cyc = 0; cyc < 600 && phase < 4; cyc++) begin
      @(posedge clk); #1;
      err_ev = 1'b0;
      if (abort_beat >= 0 && phase == 2 && beat == abort_beat) begin
        rst = 1'b1; req_valid = 1'b0; quietSlave();
        @(posedge clk); #1;
        rst = 1'b0; #1;
        checkOutput("rst_arvalid", axi_arvalid, 0);
        checkOutput("rst_awvalid", axi_awvalid, 0);
        checkOutput("rst_rready", axi_rready, 0);
        checkOutput("rst_wvalid", axi_wvalid, 0);
        checkOutput("rst_bready", axi_bready, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_pops", {req_pop, wr_pop}, 0);
`ifdef AXI_BRIDGE_ERR_STATUS_EN
        exp_err = 1'b0;
`endif
        trackErr(0);
        phase = 5;
      end else begin
        quietSlave();
        case (phase)
          1: if (rnw) axi_arready = ($urandom % 4 == 0); else axi_awready = ($urandom % 4 == 0);
          2: if (rnw) begin
               axi_rvalid = ($urandom % 3 != 0);
               axi_rlast  = (beat == int'(len));
             end else begin
               wr_valid   = ($urandom % 3 != 0);
               wr_data    = wd[beat];
               axi_wready = ($urandom % 3 != 0);
             end
          default: axi_bvalid = ($urandom % 4 == 0);
        endcase
        #1;
        checkOutput("busy_pop", req_pop, 0);
        case (phase)
          1: begin
               if (rnw) begin
                 checkOutput("arvalid", axi_arvalid, 1);
                 checkOutput("awvalid_rd", axi_awvalid, 0);
                 checkOutput("araddr", axi_araddr, 32'(addr) * 4);
                 checkOutput("arlen", axi_arlen, 32'(len));
                 checkOutput("arsize", axi_arsize, 2);
                 checkOutput("arburst", axi_arburst, 1);
                 checkOutput("arcache", axi_arcache, 3);
                 checkOutput("arid", axi_arid, 32'(id));
                 if (axi_arready) phase = 2;
               end else begin
                 checkOutput("awvalid", axi_awvalid, 1);
                 checkOutput("arvalid_wr", axi_arvalid, 0);
                 checkOutput("awaddr", axi_awaddr, 32'(addr) * 4);
                 checkOutput("awlen", axi_awlen, 32'(len));
                 checkOutput("awsize", axi_awsize, 2);
                 checkOutput("awburst", axi_awburst, 1);
                 checkOutput("awcache", axi_awcache, 3);
                 checkOutput("awid", axi_awid, 32'(id));
                 if (axi_awready) phase = 2;
               end
             end
          2: if (rnw) begin
               checkOutput("rready", axi_rready, 1);
               checkOutput("arvalid_r", axi_arvalid, 0);
               checkOutput("rd_valid", rd_valid, axi_rvalid);
               if (axi_rvalid) begin
                 checkOutput("rd_data", rd_data, axi_rdata);
                 checkOutput("rd_id", rd_id, 32'(id));
                 err_ev = (axi_rresp != 2'b00);
                 beat++;
                 if (axi_rlast) phase = 4;
               end
             end else begin
               checkOutput("awvalid_w", axi_awvalid, 0);
               checkOutput("wvalid", axi_wvalid, wr_valid);
               checkOutput("wr_pop", wr_pop, wr_valid & axi_wready);
               if (wr_valid) begin
                 checkOutput("wdata", axi_wdata, wd[beat]);
                 checkOutput("wstrb", axi_wstrb, (len == 0) ? 32'(be) : 32'hF);
                 checkOutput("wlast", axi_wlast, beat == int'(len));
               end
               if (wr_valid && axi_wready) begin
                 if (beat == int'(len)) phase = 3;
                 beat++;
               end
             end
          default: begin
               checkOutput("bready", axi_bready, 1);
               checkOutput("wvalid_b", axi_wvalid, 0);
               if (axi_bvalid) begin
                 err_ev = (axi_bresp != 2'b00);
                 phase = 4;
               end
             end
        endcase
        trackErr(err_ev);
      end
    end
    checkOutput("end_phase", phase, (abort_beat >= 0) ? 5 : 4);
    if (abort_beat < 0) checkOutput("beats", beat, int'(len) + 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0;
    req_be = '0; req_len = '0; req_id = '0;
    quietSlave();
`ifdef AXI_BRIDGE_ERR_STATUS_EN
    exp_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    checkOutput("reset_arvalid", axi_arvalid, 0);
    checkOutput("reset_awvalid", axi_awvalid, 0);
    checkOutput("reset_rready", axi_rready, 0);
    checkOutput("reset_wvalid", axi_wvalid, 0);
    checkOutput("reset_bready", axi_bready, 0);
    checkOutput("reset_pops", {req_pop, wr_pop, rd_valid}, 0);
    checkOutput("reset_araddr", axi_araddr, 0);
    checkOutput("reset_arlen", axi_arlen, 0);
    trackErr(0);

    $display("[TB] directed transactions");
    applyStimulus(1'b1, 30'h400, 5'd0, 4'hF, 2'd1, 1, -1);
    applyStimulus(1'b1, 30'h1234, 5'd7, 4'hF, 2'd2, 0, -1);
    applyStimulus(1'b0, 30'h2000, 5'd0, 4'b0011, 2'd3, 2, -1);
    applyStimulus(1'b0, 30'h3000, 5'd3, 4'b0001, 2'd0, 0, -1);
    applyStimulus(1'b1, 30'h0, 5'd31, 4'hF, 2'd1, 0, -1);
    applyStimulus(1'b0, 30'h3FFFFFFF, 5'd31, 4'h5, 2'd2, 0, -1);
    applyStimulus(1'b1, 30'h55, 5'd7, 4'hF, 2'd2, 1, 3);
    applyStimulus(1'b0, 30'h77, 5'd1, 4'h9, 2'd1, 0, -1);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      logic [4:0] ln;
      case ($urandom % 4)
        0: ln = 5'd0;
        1: ln = 5'd31;
        default: ln = 5'($urandom);
      endcase
      applyStimulus(1'($urandom), 30'($urandom), ln, 4'($urandom), 2'($urandom),
                    $urandom % 3, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_to_arb_bridge.md
Name: axi_to_arb_bridge

Overview:
- Bridges the L2 arbiter's memory-side request port to a 32-bit AXI4 master port (DDR/interconnect).
- Sits between the L2 arbiter output and external memory.
- Converts one arbitrated request (single word or burst) into AXI AR/R or AW/W/B transactions and returns read data tagged with the request id.
- Only one transaction is in flight at a time.

Parameters:
- ID_W, 2: width of the L2 request/return id.
- AXI_ID_W, 6: width of the AXI id fields; the L2 id is zero-extended into it.
- BURST_W, 5: width of the burst-length field (beats minus 1).

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  arbitrated request available
req_pop  out  1  request consumed this cycle
req_addr  in  30  word address (byte address [31:2])
req_rnw  in  1  1=read, 0=write
req_be  in  4  byte enables for single-word writes
req_len  in  BURST_W  beats minus 1
req_id  in  ID_W  requester id
wr_valid  in  1  write-data word available
wr_data  in  32  write-data word
wr_pop  out  1  write-data word consumed
rd_data  out  32  returned read word
rd_id  out  ID_W  id of the returned word
rd_valid  out  1  rd_data valid this cycle
axi_ar*  out  -  araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arcache[3:0], arid[AXI_ID_W-1:0], arvalid
axi_arready  in  1  read-address ready
axi_rdata/rresp/rlast/rvalid/rid  in  32/2/1/1/AXI_ID_W  read-data channel
axi_rready  out  1  read-data ready
axi_aw*  out  -  awaddr, awlen, awsize, awburst, awcache, awid, awvalid (same widths as AR)
axi_awready  in  1  write-address ready
axi_wdata/wstrb/wlast/wvalid  out  32/4/1/1  write-data channel
axi_wready  in  1  write-data ready
axi_bresp/bvalid  in  2/1  write-response channel
axi_bready  out  1  write-response ready

Interface convention (already decided): reset rst, synchronous, active-high; clock clk.

Behaviour:
- FSM states: IDLE, AR, R, AW, W, B.
- Reset: state=IDLE. All valid/ready/pop outputs are 0. Latched address/len/id/be, beat counter and error flag are 0.

IDLE
- When req_valid=1: req_pop=1 combinationally for that one cycle.
- Latch addr, rnw, be, len and id.
- Next state is AR if rnw=1, else AW.

Address phases (AR/AW)
- axi_a*addr = {addr, 2'b00}; a*len = {0, len}; a*size = 3'b010; a*burst = 2'b01 (INCR); a*cache = 4'b0011; a*id = zero-extended id.
- a*valid is held high and its fields held stable until the ready handshake.
- On handshake: AR→R, AW→W.

R
- rready=1.
- rd_valid = rvalid & rready; rd_data = rdata; rd_id = latched id. All combinational, zero added latency.
- The beat with rlast=1 → IDLE.
- rid is ignored.

W
- wvalid = wr_valid; wdata = wr_data.
- wstrb = latched be when len=0, else 4'hF.
- wlast = (beat counter == len).
- wr_pop = wvalid & wready. The beat counter increments on each pop.
- The pop with wlast=1 → B.

B
- bready=1.
- bvalid → IDLE; the beat counter clears.

Boundaries
- req_valid while not IDLE: ignored; req_pop stays 0.
- wr_valid low mid-burst: wvalid drops and the counter holds (no bubble penalty).
- len=0 (single beat): wlast=1 on the first beat.
- len=31: 32 beats.
- rresp/bresp errors do not alter the flow.
- rst asserted mid-transaction: returns immediately to IDLE with all outputs cleared. The external AXI slave must also be reset.

Optional Feature:
- Macro: AXI_BRIDGE_ERR_STATUS_EN.
- Defined: adds output port err_sticky (1 bit).
  - It is set on any R beat with rresp≠0, or on a B handshake with bresp≠0.
  - It is cleared only by rst.
  - Transaction flow is unchanged.
- Undefined: no port and no logic; error responses are silently ignored.

Test Plan:
- Single read: req addr=0x0000_0400 (word), len=0, id=1; slave arready after 5 cycles, rdata=0xFFFFFF21 with rlast → araddr=0x1000, arlen=0, arsize=2, arid=1; rd_valid for one cycle with rd_data=0xFFFFFF21, rd_id=1; FSM back in IDLE.
- 8-beat read burst, len=7, with rvalid gaps → exactly 8 rd_valid pulses in order; returns to IDLE only after the rlast beat.
- Single write: be=4'b0011, data 0xA5A5_1234, slave wready after 5 cycles → awaddr matches; wstrb=0011; wlast=1; wr_pop once; bready held until bvalid; then IDLE.
- 4-beat write burst (len=3) with wr_valid deasserted on beat 2 for 3 cycles → wstrb=F; wlast only on the 4th beat; 4 wr_pop pulses total.
- Back-to-back: req_valid held high with a read then a write queued → req_pop exactly once per transaction, the second only after the first returns to IDLE; no overlap of AR and AW.
- Reset in R state mid-burst → next cycle all valids and pops are 0 and state is IDLE. With AXI_BRIDGE_ERR_STATUS_EN: bresp=2'b10 sets err_sticky, and it stays set until rst.
